seg7_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit seven-segment display, sitting directly downstream of `outputs`. It consumes the packed 32-bit `seg7_num` word (one segment pattern per digit) and scans it onto a shared segment bus with per-digit anode enables. It also provides frame-coherent updates, per-digit blanking and blinking, and 8-level brightness PWM.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/tick_div.sv | 32 +++
 rtl/seg7_scan.sv | 126 ++++++++++++
 tb/tb_seg7_scan.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit seven-segment scan driver:
// digit count, segment bit positions, pattern type and output polarity helper.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 32'd4;

    localparam int unsigned SEG_A  = 32'd0;
    localparam int unsigned SEG_B  = 32'd1;
    localparam int unsigned SEG_C  = 32'd2;
    localparam int unsigned SEG_D  = 32'd3;
    localparam int unsigned SEG_E  = 32'd4;
    localparam int unsigned SEG_F  = 32'd5;
    localparam int unsigned SEG_G  = 32'd6;
    localparam int unsigned SEG_DP = 32'd7;

    typedef logic [7:0] seg_pat_t;

    // Convert an active-high pattern (1 = lit/enabled) to the board's drive level.
    function automatic seg_pat_t apply_pol(input seg_pat_t val, input logic active_low);
        seg_pat_t res;
        if (active_low) begin
            res = ~val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Parameterised prescaler: counts 0..DIV-1 and flags the terminal count
// with a one-cycle tick; the running count is exported for slot-start decode.
module tick_div #(
    parameter int unsigned DIV = 32'd6250,
    localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] TERM = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    logic [CW-1:0] cnt_r;

    // Free-running prescale counter, wrapping at the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == TERM) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == TERM);
    assign cnt  = cnt_r;

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit seven-segment driver with frame-coherent shadows,
// per-digit blank/blink and 8-level PWM brightness.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SUB_DIV    = 32'd6250,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg7_num,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    input  logic [2:0]  bright,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int unsigned CW        = (SUB_DIV > 32'd1) ? $clog2(SUB_DIV) : 32'd1;
    localparam seg_pat_t    OFF_LEVEL = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic          sub_tick_s;
    logic [CW-1:0] sub_cnt_s;

    logic [2:0]  phase_r;
    logic [1:0]  digit_r;
    logic [4:0]  frame_cnt_r;
    logic [2:0]  bright_q_r;
    logic [31:0] shadow_num_r;
    logic [3:0]  shadow_blank_r;
    logic [3:0]  shadow_blink_r;

    logic        slot_start_s;
    logic        frame_start_s;
    logic        lit_s;
    seg_pat_t    seg_next_s;
    logic [3:0]  an_next_s;
    seg_pat_t    seg_pol_s;
    seg_pat_t    an_pol_s;

    seg_pat_t    seg_r;
    logic [3:0]  an_r;
    logic        frame_r;

    tick_div #(.DIV(SUB_DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (sub_tick_s),
        .cnt  (sub_cnt_s)
    );

    // All counters at zero marks a frame start, including the first cycle out of reset.
    assign slot_start_s  = (sub_cnt_s == {CW{1'b0}}) && (phase_r == 3'd0);
    assign frame_start_s = slot_start_s && (digit_r == 2'd0);

    // PWM phase within a slot and the digit being scanned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 3'd0;
            digit_r <= 2'd0;
        end else if (sub_tick_s) begin
            phase_r <= phase_r + 3'd1;
            if (phase_r == 3'd7) begin
                digit_r <= digit_r + 2'd1;
            end
        end
    end

    // Frame-coherent shadows, blink frame counter and per-slot brightness sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_num_r   <= 32'h0000_0000;
            shadow_blank_r <= 4'b0000;
            shadow_blink_r <= 4'b0000;
            frame_cnt_r    <= 5'd0;
            bright_q_r     <= 3'd0;
        end else begin
            if (frame_start_s) begin
                shadow_num_r   <= seg7_num;
                shadow_blank_r <= blank_mask;
                shadow_blink_r <= blink_mask;
                frame_cnt_r    <= frame_cnt_r + 5'd1;
            end
            if (slot_start_s) begin
                bright_q_r <= bright;
            end
        end
    end

    // Lit decision (phase 0 is dead time) and active-high pattern select
    always_comb begin
        seg_next_s = 8'h00;
        an_next_s  = 4'b0000;
        lit_s      = (phase_r != 3'd0) && (phase_r <= bright_q_r) &&
                     !shadow_blank_r[digit_r] &&
                     !(shadow_blink_r[digit_r] && frame_cnt_r[4]);
        if (lit_s) begin
            seg_next_s = shadow_num_r[{digit_r, 3'b000} +: 8];
            an_next_s  = 4'b0001 << digit_r;
        end else begin
            seg_next_s = 8'h00;
            an_next_s  = 4'b0000;
        end
        seg_pol_s = apply_pol(seg_next_s, ACTIVE_LOW);
        an_pol_s  = apply_pol({4'b0000, an_next_s}, ACTIVE_LOW);
    end

    // Output registers at drive polarity; reset forces the display dark at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r   <= OFF_LEVEL;
            an_r    <= OFF_LEVEL[3:0];
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_pol_s;
            an_r    <= an_pol_s[3:0];
            frame_r <= frame_start_s;
        end
    end

    assign seg   = seg_r;
    assign an    = an_r;
    assign frame = frame_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SUB_DIV = 2 (16-clk slot,
// 64-clk frame); an ACTIVE_LOW = 0 twin shares the stimulus for polarity checks.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] seg7_num   = 32'h3F06_5B4F;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [2:0]  bright     = 3'd7;

    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
    logic [7:0] seg_hi;
    logic [3:0] an_hi;
    logic       frame_hi;

    int checks = 0;
    int errors = 0;
    int n;
    int lit_cnt [4];
    int multi_cnt;
    int bad_cnt;
    int d;
    int p;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [7:0] pat [4];

    seg7_scan #(.SUB_DIV(32'd2), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .seg7_num(seg7_num), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .bright(bright), .seg(seg), .an(an), .frame(frame)
    );

    seg7_scan #(.SUB_DIV(32'd2), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .seg7_num(seg7_num), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .bright(bright), .seg(seg_hi), .an(an_hi), .frame(frame_hi)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        multi_cnt = 0;
        bad_cnt   = 0;
    endtask

    // Sample on the falling edge; n is the index of the counter state shown on the outputs
    task automatic tick();
        int zeros;
        @(negedge clk);
        n++;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (an[i] === 1'b0) begin
                lit_cnt[i]++;
                zeros++;
            end
        end
        if (zeros > 1) multi_cnt++;
    endtask

    task automatic restart();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = -1;
        clear_counts();
    endtask

    initial begin
        pat[0] = 8'h4F; pat[1] = 8'h5B; pat[2] = 8'h06; pat[3] = 8'h3F;
        n = -1;
        clear_counts();

        // Basic scan, bright 7: every cycle of the first frame
        restart();
        for (int k = 0; k < 64; k++) begin
            tick();
            d = n / 16;
            p = (n / 2) % 8;
            e_an  = 4'hF;
            e_seg = 8'hFF;
            if (p != 0) begin
                e_an[d] = 1'b0;
                e_seg   = ~pat[d];
            end
            check_val("scan_an", an, e_an);
            check_val("scan_seg", seg, e_seg);
            if (n == 0) check_val("first_frame_pulse", frame, 1'b1);
            if (n == 1) check_val("frame_pulse_width", frame, 1'b0);
            if (n == 2) begin
                check_val("d0_an", an, 4'b1110);
                check_val("d0_seg", seg, 8'hB0);
                check_val("hi_d0_an", an_hi, 4'b0001);
                check_val("hi_d0_seg", seg_hi, 8'h4F);
            end
            if (n == 50) begin
                check_val("d3_an", an, 4'b0111);
                check_val("d3_seg", seg, 8'hC0);
                check_val("hi_d3_an", an_hi, 4'b1000);
                check_val("hi_d3_seg", seg_hi, 8'h3F);
            end
        end
        check_val("one_anode", multi_cnt, 0);
        for (int i = 0; i < 4; i++) check_val("b7_lit_clks", lit_cnt[i], 14);

        // Reset mid-slot: outputs dark asynchronously, scan restarts at digit 0
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check_val("rst_an", an, 4'hF);
        check_val("rst_seg", seg, 8'hFF);
        check_val("rst_frame", frame, 1'b0);
        check_val("hi_rst_an", an_hi, 4'h0);
        check_val("hi_rst_seg", seg_hi, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = -1;
        tick();
        check_val("post_rst_frame", frame, 1'b1);
        check_val("post_rst_dark", an, 4'hF);
        tick();
        check_val("post_rst_frame_end", frame, 1'b0);
        tick();
        check_val("post_rst_d0_an", an, 4'b1110);
        check_val("post_rst_d0_seg", seg, 8'hB0);

        // Brightness 3 -> 6 lit clks per digit; brightness 0 -> always dark
        bright = 3'd3;
        restart();
        repeat (64) tick();
        for (int i = 0; i < 4; i++) check_val("b3_lit_clks", lit_cnt[i], 6);
        bright = 3'd0;
        restart();
        repeat (64) tick();
        check_val("b0_lit_clks", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

        // Frame coherency: change the word during digit 1, new pattern waits for next frame
        bright   = 3'd7;
        seg7_num = 32'h0000_0000;
        restart();
        for (int k = 0; k < 67; k++) begin
            tick();
            if (n < 66 && seg !== 8'hFF) bad_cnt++;
            if (n == 20) seg7_num = 32'hFFFF_FFFF;
            if (n == 64) check_val("coh_frame", frame, 1'b1);
            if (n == 66) begin
                check_val("coh_new_seg", seg, 8'h00);
                check_val("coh_new_an", an, 4'b1110);
            end
        end
        check_val("coh_no_tear", bad_cnt, 0);

        // Blanking digit 2
        seg7_num   = 32'h3F06_5B4F;
        blank_mask = 4'b0100;
        restart();
        repeat (64) tick();
        check_val("blank_d2", lit_cnt[2], 0);
        check_val("blank_d1", lit_cnt[1], 14);

        // Blinking digit 0 over 34 frames
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        restart();
        for (int k = 0; k < 34; k++) begin
            clear_counts();
            repeat (64) tick();
            if (k == 0) check_val("blink_f0_lit", lit_cnt[0], 14);
            if (k == 20) begin
                check_val("blink_f20_dark", lit_cnt[0], 0);
                check_val("blink_f20_d3", lit_cnt[3], 14);
            end
            if (k == 33) check_val("blink_f33_lit", lit_cnt[0], 14);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
